keypad_scanner: RTL and testbench
=================================

# keypad_scanner

4x4 matrix keypad input block: drives keypad rows, samples columns, debounces press and release, and reports one hex code per keystroke. Each accepted key is shifted into a 16-bit entry register that the CPU reads and the seven-segment display path shows, so the on-board display echoes typed digits.

## Interface
Parameters:
- SCAN_DIV, 50000: clk cycles each row is driven before the scan advances; minimum 4.
- DEBOUNCE_CNT, 500000: consecutive stable cycles required to accept a press or a release; minimum 2.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-low reset.
- col  input  4  keypad column lines, active-low, pulled up externally, asynchronous to clk.
- clr  input  1  synchronous clear of `value`, active-high.
- row  output  4  keypad row drive, active-low, exactly one bit low at all times.
- key_code  output  4  code of the last accepted key.
- key_valid  output  1  one-cycle pulse per accepted key.
- key_down  output  1  high from acceptance until release is debounced.
- value  output  16  entry register, newest key in [3:0].

## Operation
- Column input passes through a 2-flop synchronizer (`col_s`), reset value 4'hF; all decisions use `col_s`.
- Key code = {row_index[1:0], col_index[1:0]}, giving row 0/col 0 = 0x0 through row 3/col 3 = 0xF.
- If several columns are low in one row, the lowest column index is taken.
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
  - SCAN: a divider counts 0..SCAN_DIV-1 per row.
    - At count SCAN_DIV-1: if `col_s` != 4'hF, capture `col_s` and the row index and go to DEBOUNCE with row held. Otherwise advance row_index (3 wraps to 0) and restart the divider.
  - DEBOUNCE: the counter increments while `col_s` equals the captured pattern.
    - On reaching DEBOUNCE_CNT-1 with a match, go to PRESSED.
    - Any mismatch goes to SCAN, advancing to the next row; no key is reported.
  - PRESSED (one cycle): `key_valid`=1, `key_code` loaded, value <= {value[11:0], code}, then go to RELEASE.
  - RELEASE: row stays held. The counter clears whenever `col_s` != 4'hF and increments while `col_s` == 4'hF. Reaching DEBOUNCE_CNT-1 returns to SCAN at the next row.
- `key_down` is 1 in PRESSED and RELEASE, 0 otherwise.
- A second key pressed while the first is held is ignored; no new code is reported until all columns have been high for DEBOUNCE_CNT cycles.
- `clr`: value <= 0 on the next edge. If `clr` coincides with PRESSED, `clr` wins and value = 0, but `key_valid` and `key_code` still report the key.
- `key_code` holds its value until the next accepted key.

## Timing
- Reset (rst=0), asynchronously: row=4'b1110 (row 0), key_code=0, key_valid=0, key_down=0, value=0, FSM=SCAN, divider and counter 0, `col_s`=4'hF.
- Reset mid-press discards the key; after reset the key must be released and pressed again to be reported.
- All outputs are registered; there is no combinational path from `col` to any output.
- Press latency from the first matching `col_s` cycle in DEBOUNCE: PRESSED is entered DEBOUNCE_CNT cycles later.
- `key_valid` is high for exactly 1 cycle per keystroke.
- `value` and `key_code` update on the same edge that raises `key_valid`.
- `key_down` falls on the edge that enters SCAN after the release is debounced.
- Full scan period with no key pressed = 4*SCAN_DIV cycles.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=8.
1. Reset, no key pressed → row cycles 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; key_valid never asserts; value=0x0000.
2. Hold row 2/col 1 low for 40 cycles, then release for 20 → exactly one key_valid pulse, key_code=0x9, value=0x0009; key_down high from the pulse until 8 cycles of high columns.
3. Press keys 0x1, 0x2, 0x3, 0x4, 0xA in sequence, each cleanly pressed and released → value=0x234A after the fifth pulse, and 0x0001 is shifted out.
4. Bounce on row 1/col 3: toggle the column every 3 cycles for 20 cycles, then hold it stable → no pulse during the bounce; one pulse with key_code=0x7 after 8 stable cycles. Release with bounce → no extra pulse.
5. Hold row 0/col 0, then also press row 0/col 2 and row 3/col 1 → a single pulse with code 0x0; no pulse for the other keys until all are released.
6. Assert clr on the same cycle as PRESSED for key 0x5 → key_valid=1, key_code=0x5, value=0x0000. Pull rst low during DEBOUNCE → all outputs return to their reset values immediately and no pulse follows.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row drive, debounces column
// activity on the held row, and shifts each accepted hex key into a 16-bit entry register.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    input  logic        clr,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] value
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t            state_q;
    logic [3:0]        col_meta_q, col_s_q;
    logic [1:0]        row_idx_q;
    logic [1:0]        row_idx_d;
    logic [3:0]        row_q;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        cap_col_q;
    logic [3:0]        cap_code_q;
    logic [3:0]        key_code_q;
    logic              key_valid_q;
    logic              key_down_q;
    logic [15:0]       value_q;
    logic              armed_q;
    logic [1:0]        quiet_q;
    logic              col_hit;

    function automatic logic [1:0] lowest_col(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    assign row_idx_d = row_idx_q + 2'd1;
    assign col_hit   = (col_s_q != 4'hF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
        end else begin
            col_meta_q <= col;
            col_s_q    <= col_meta_q;
        end
    end

    // After reset, keys are ignored until four consecutive rows scan clean, so a
    // key held through reset has to be released and pressed again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            row_q       <= 4'b1110;
            div_q       <= '0;
            cnt_q       <= '0;
            cap_col_q   <= 4'hF;
            cap_code_q  <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            value_q     <= 16'h0000;
            armed_q     <= 1'b0;
            quiet_q     <= 2'd0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (col_hit && armed_q) begin
                            cap_col_q  <= col_s_q;
                            cap_code_q <= {row_idx_q, lowest_col(col_s_q)};
                            cnt_q      <= '0;
                            state_q    <= DEBOUNCE;
                        end else begin
                            row_idx_q <= row_idx_d;
                            row_q     <= row_drive(row_idx_d);
                            if (!armed_q) begin
                                if (col_hit)              quiet_q <= 2'd0;
                                else if (quiet_q == 2'd3) armed_q <= 1'b1;
                                else                      quiet_q <= quiet_q + 2'd1;
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (col_s_q == cap_col_q) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q     <= PRESSED;
                            key_valid_q <= 1'b1;
                            key_down_q  <= 1'b1;
                            key_code_q  <= cap_code_q;
                            value_q     <= {value_q[11:0], cap_code_q};
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_q   <= SCAN;
                        div_q     <= '0;
                        row_idx_q <= row_idx_d;
                        row_q     <= row_drive(row_idx_d);
                    end
                end
                PRESSED: begin
                    state_q <= RELEASE;
                    cnt_q   <= '0;
                end
                RELEASE: begin
                    if (col_hit) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= SCAN;
                        key_down_q <= 1'b0;
                        div_q      <= '0;
                        row_idx_q  <= row_idx_d;
                        row_q      <= row_drive(row_idx_d);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= SCAN;
            endcase
            if (clr) value_q <= 16'h0000;
        end
    end

    assign row       = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign value     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a small keypad matrix model closes switches
// between driven rows and sensed columns; expected codes and values are hand-computed.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col;
    logic        clr;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] value;

    logic [15:0] keys;
    int          n_chk   = 0;
    int          n_pass  = 0;
    int          n_pulse = 0;
    logic        found;
    logic [3:0]  exp_row;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .clr       (clr),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .value     (value)
    );

    always #5 clk = ~clk;

    // Closed switch (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4+c]) col[c] = 1'b0;
    end

    always @(posedge clk) if (key_valid === 1'b1) n_pulse <= n_pulse + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic stroke(input int code);
        keys[code] = 1'b1;
        tick(40);
        keys[code] = 1'b0;
        tick(20);
    endtask

    initial begin
        rst  = 1'b0;
        clr  = 1'b0;
        keys = '0;
        tick(2);
        check("rst_row", row, 4'b1110);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_down", key_down, 0);
        check("rst_value", value, 0);

        // 1: idle scan, row changes every 4 cycles
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            check("t1_row", row, exp_row);
        end
        check("t1_no_pulse", n_pulse, 0);
        check("t1_value", value, 0);

        // 2: single key 0x9, release timing
        keys[9] = 1'b1;
        tick(40);
        check("t2_pulses", n_pulse, 1);
        check("t2_code", key_code, 4'h9);
        check("t2_value", value, 16'h0009);
        check("t2_down_held", key_down, 1);
        keys[9] = 1'b0;
        tick(9);
        check("t2_down_before", key_down, 1);
        tick(1);
        check("t2_down_after", key_down, 0);
        tick(10);
        check("t2_pulses_end", n_pulse, 1);

        // 3: key sequence
        stroke(1); stroke(2); stroke(3); stroke(4); stroke(10);
        check("t3_pulses", n_pulse, 6);
        check("t3_code", key_code, 4'hA);
        check("t3_value", value, 16'h234A);

        // 4: bounce on press and release of key 0x7
        for (int i = 0; i < 7; i++) begin
            keys[7] = (i % 2 == 0);
            tick(3);
        end
        check("t4_bounce_nopulse", n_pulse, 6);
        keys[7] = 1'b1;
        tick(40);
        check("t4_pulses", n_pulse, 7);
        check("t4_code", key_code, 4'h7);
        for (int i = 0; i < 7; i++) begin
            keys[7] = (i % 2 == 1);
            tick(3);
        end
        check("t4_down_bounce", key_down, 1);
        keys[7] = 1'b0;
        tick(20);
        check("t4_pulses_end", n_pulse, 7);
        check("t4_down_end", key_down, 0);
        check("t4_value", value, 16'h34A7);

        // 5: multi-key rollover ignored
        keys[0] = 1'b1;
        tick(40);
        check("t5_pulses", n_pulse, 8);
        check("t5_code", key_code, 4'h0);
        keys[2]  = 1'b1;
        keys[13] = 1'b1;
        tick(40);
        check("t5_extra_nopulse", n_pulse, 8);
        keys[0] = 1'b0;
        tick(40);
        check("t5_partial_nopulse", n_pulse, 8);
        check("t5_partial_down", key_down, 1);
        keys = '0;
        tick(20);
        check("t5_down_end", key_down, 0);
        check("t5_value", value, 16'h4A70);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t5_clr", value, 0);

        // 6: clr concurrent with acceptance, then reset mid-debounce
        keys[5] = 1'b1;
        clr     = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            if (key_valid === 1'b1) found = 1'b1;
        end
        check("t6_valid_seen", found, 1);
        check("t6_code", key_code, 4'h5);
        check("t6_value_clr", value, 0);
        tick(1);
        clr = 1'b0;
        check("t6_valid_width", key_valid, 0);
        tick(40);
        check("t6_pulses", n_pulse, 9);
        keys[5] = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1);
            if (key_down === 1'b0) found = 1'b1;
        end
        check("t6_release_seen", found, 1);
        keys[8] = 1'b1;
        tick(7);
        check("t6_row_held", row, 4'b1011);
        rst = 1'b0;
        #1;
        check("t6_rst_row", row, 4'b1110);
        check("t6_rst_code", key_code, 0);
        check("t6_rst_valid", key_valid, 0);
        check("t6_rst_down", key_down, 0);
        check("t6_rst_value", value, 0);
        tick(2);
        rst = 1'b1;
        tick(40);
        check("t6_held_nopulse", n_pulse, 9);
        check("t6_held_down", key_down, 0);
        keys[8] = 1'b0;
        tick(30);
        stroke(8);
        check("t6_repress_pulses", n_pulse, 10);
        check("t6_repress_code", key_code, 4'h8);
        check("t6_repress_value", value, 16'h0008);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
